// File: rtl/serial_pkg.sv
// Shared types and constants for the serial word assembler and its shift register.
// The optional parity stage is enabled with the macro SERIAL_WORD_ASSEMBLER_PARITY_EN.
package serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Must match the width of the downstream enabled register stage.
    localparam int WORD_W = 4;

endpackage

// File: rtl/serial_shift_reg.sv
// WIDTH-bit left-shift register: new bits enter at the LSB, so MSB-first data lands in order.
// Synchronous active-low clear.
module serial_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (shift_en_i) begin
            data_d = {data_q[WIDTH-2:0], bit_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Deserialises start/data(MSB first)/stop frames into a word plus a one-cycle load strobe.
// Define SERIAL_WORD_ASSEMBLER_PARITY_EN to insert an even-parity bit between data and stop.
module serial_word_assembler
    import serial_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] word,
    output logic             word_en,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_en_q, word_en_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             shift_en;
    logic [WIDTH-1:0] shift_data;

    serial_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .shift_en_i(shift_en),
        .bit_i     (sin),
        .data_o    (shift_data)
    );

    // Nothing advances without a bit strobe; the error/load strobes always self-clear.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_d       = word_q;
        word_en_d    = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        shift_en     = 1'b0;

        if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (sin == START_BIT) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
                S_PARITY: begin
                    if (sin == (^shift_data)) begin
                        state_d = S_STOP;
                    end else begin
                        parity_err_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
`endif
                S_STOP: begin
                    // A zero here is a framing error, not the start of the next frame.
                    if (sin == STOP_BIT) begin
                        word_d    = shift_data;
                        word_en_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            word_q       <= '0;
            word_en_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_q       <= word_d;
            word_en_q    <= word_en_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign word       = word_q;
    assign word_en    = word_en_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_word_assembler.sv
// Self-checking bench for serial_word_assembler: directed vector table, hand-written
// corner sequences and random traffic compared against a frame-level reference model.
module tb_serial_word_assembler;

    localparam int W = 4;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         sin = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] word;
    logic         word_en;
    logic         frame_err;
    logic         parity_err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    serial_word_assembler #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .in_valid  (in_valid),
        .word      (word),
        .word_en   (word_en),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: collects the bits that follow a start bit and judges the
    // frame once the parity / stop position is reached.
    bit           mInFrame = 1'b0;
    bit           mBits[$];
    logic [W-1:0] mWord = '0;
    bit           mEn = 1'b0;
    bit           mFerr = 1'b0;
    bit           mPerr = 1'b0;

    task automatic modelStep(input logic r, input logic v, input logic s);
        int ones;
        int val;
        if (!r) begin
            mInFrame = 1'b0;
            mBits.delete();
            mWord = '0;
            mEn = 1'b0;
            mFerr = 1'b0;
            mPerr = 1'b0;
        end else begin
            mEn = 1'b0;
            mFerr = 1'b0;
            mPerr = 1'b0;
            if (v) begin
                if (!mInFrame) begin
                    if (s == 1'b0) begin
                        mInFrame = 1'b1;
                        mBits.delete();
                    end
                end else begin
                    mBits.push_back(s);
                    if (P == 1 && mBits.size() == W + 1) begin
                        ones = 0;
                        for (int i = 0; i < W; i++) ones += int'(mBits[i]);
                        if (int'(s) != (ones % 2)) begin
                            mPerr = 1'b1;
                            mInFrame = 1'b0;
                        end
                    end else if (mBits.size() == W + 1 + P) begin
                        mInFrame = 1'b0;
                        if (s) begin
                            val = 0;
                            for (int i = 0; i < W; i++) val = val * 2 + int'(mBits[i]);
                            mWord = W'(val);
                            mEn = 1'b1;
                        end else begin
                            mFerr = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model on the same edge and compare #1 later.
    task automatic applyStimulus(input logic r, input logic v, input logic s);
        reset = r;
        in_valid = v;
        sin = s;
        @(posedge clk);
        modelStep(r, v, s);
        #1;
        checkOutput("word", 32'(word), 32'(mWord));
        checkOutput("word_en", 32'(word_en), 32'(mEn));
        checkOutput("frame_err", 32'(frame_err), 32'(mFerr));
        checkOutput("parity_err", 32'(parity_err), 32'(mPerr));
        checkOutput("busy", 32'(busy), 32'(mInFrame));
    endtask

    task automatic sendBit(input logic s, input int gap);
        for (int g = 0; g < gap; g++) applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        applyStimulus(1'b1, 1'b1, s);
    endtask

    task automatic sendFrame(input logic [W-1:0] d, input logic par, input logic stopBit, input int gap);
        sendBit(1'b0, gap);
        for (int i = W - 1; i >= 0; i--) sendBit(d[i], gap);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        sendBit(par, gap);
`endif
        sendBit(stopBit, gap);
    endtask

    typedef struct {
        logic         rst;
        logic         v;
        logic         s;
        logic [W-1:0] word;
        logic         en;
        logic         ferr;
        logic         busy;
    } vec_t;

    vec_t tbl[$];

    task automatic addVec(input logic r, input logic v, input logic s, input logic [W-1:0] w,
                          input logic en, input logic ferr, input logic b);
        vec_t t;
        t.rst = r; t.v = v; t.s = s; t.word = w; t.en = en; t.ferr = ferr; t.busy = b;
        tbl.push_back(t);
    endtask

    initial begin
        // Reset, then idle line.
        addVec(0, 0, 1, 4'h0, 0, 0, 0);
        addVec(0, 1, 0, 4'h0, 0, 0, 0);
        for (int i = 0; i < 10; i++) addVec(1, 1, 1, 4'h0, 0, 0, 0);
        // Good frame 1011.
        addVec(1, 1, 0, 4'h0, 0, 0, 1);
        addVec(1, 1, 1, 4'h0, 0, 0, 1);
        addVec(1, 1, 0, 4'h0, 0, 0, 1);
        addVec(1, 1, 1, 4'h0, 0, 0, 1);
        addVec(1, 1, 1, 4'h0, 0, 0, 1);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        addVec(1, 1, 1, 4'h0, 0, 0, 1);
`endif
        addVec(1, 1, 1, 4'hB, 1, 0, 0);
        addVec(1, 0, 0, 4'hB, 0, 0, 0);
        // Bad stop bit on data 1100.
        addVec(1, 1, 0, 4'hB, 0, 0, 1);
        addVec(1, 1, 1, 4'hB, 0, 0, 1);
        addVec(1, 1, 1, 4'hB, 0, 0, 1);
        addVec(1, 1, 0, 4'hB, 0, 0, 1);
        addVec(1, 1, 0, 4'hB, 0, 0, 1);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        addVec(1, 1, 0, 4'hB, 0, 0, 1);
`endif
        addVec(1, 1, 0, 4'hB, 0, 1, 0);
        addVec(1, 1, 1, 4'hB, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].v, tbl[i].s);
            checkOutput("tbl_word", 32'(word), 32'(tbl[i].word));
            checkOutput("tbl_word_en", 32'(word_en), 32'(tbl[i].en));
            checkOutput("tbl_frame_err", 32'(frame_err), 32'(tbl[i].ferr));
            checkOutput("tbl_busy", 32'(busy), 32'(tbl[i].busy));
        end

        // Gapped strobes with random sin during the gaps.
        sendFrame(4'b0101, 1'b0, 1'b1, 0);
        checkOutput("pre_gap_word", 32'(word), 32'h5);
        sendFrame(4'b1011, 1'b1, 1'b1, 3);
        checkOutput("gap_word", 32'(word), 32'hB);

        // Mid-frame reset followed by a full frame 0110.
        sendBit(1'b0, 0);
        sendBit(1'b1, 0);
        sendBit(1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rst_word", 32'(word), 32'h0);
        sendFrame(4'b0110, 1'b0, 1'b1, 0);
        checkOutput("after_rst_word", 32'(word), 32'h6);

        // Back-to-back frames with no idle bit between them.
        sendFrame(4'b1110, 1'b1, 1'b1, 0);
        sendFrame(4'b0011, 1'b0, 1'b1, 0);
        checkOutput("b2b_word", 32'(word), 32'h3);
        sendFrame(4'b0110, 1'b0, 1'b1, 0);

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        // Data 1001 has even parity 0; a parity bit of 1 must be rejected.
        sendBit(1'b0, 0);
        sendBit(1'b1, 0);
        sendBit(1'b0, 0);
        sendBit(1'b0, 0);
        sendBit(1'b1, 0);
        sendBit(1'b1, 0);
        checkOutput("par_err_pulse", 32'(parity_err), 32'h1);
        checkOutput("par_err_busy", 32'(busy), 32'h0);
        sendBit(1'b1, 0);
        checkOutput("par_bad_word", 32'(word), 32'h6);
        sendFrame(4'b1001, 1'b0, 1'b1, 0);
        checkOutput("par_good_word", 32'(word), 32'h9);
`endif

        // Random well-formed and corrupted frames.
        for (int f = 0; f < 100; f++) begin
            logic [W-1:0] d;
            logic         p;
            d = W'($urandom);
            p = ^d;
            if ($urandom_range(0, 9) == 0) p = ~p;
            sendFrame(d, p, ($urandom_range(0, 9) != 0), $urandom_range(0, 2));
        end

        // Unstructured random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
